text_console_ctrl: RTL and testbench

Parametrised text-terminal cursor and character-buffer write controller. It sits between the keyboard path (scancode to ASCII) and the dual-use character buffer read by the VGA character renderer. It accepts ASCII codes over a valid/ready handshake and issues buffer writes. It tracks the cursor, per-line lengths and a hardware scroll offset. Beyond the previous terminal logic, it adds CR/LF/TAB/form-feed handling, a correct backspace across wrapped lines, full-buffer clear on reset, and flow control.

---
 rtl/console_pkg.sv | 19 +
 rtl/line_len_table.sv | 36 +++
 rtl/text_console_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants and state encoding for the text console write controller.
package console_pkg;

    localparam logic [7:0] ASC_BS       = 8'h08;
    localparam logic [7:0] ASC_HT       = 8'h09;
    localparam logic [7:0] ASC_LF       = 8'h0A;
    localparam logic [7:0] ASC_FF       = 8'h0C;
    localparam logic [7:0] ASC_CR       = 8'h0D;
    localparam logic [7:0] ASC_PRINT_LO = 8'h20;
    localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        WRITE,
        CLR_LINE
    } state_e;

endpackage

// File: rtl/line_len_table.sv
// Per-physical-row line length store: sync writes, async read, bulk clear.
module line_len_table #(
    parameter int unsigned ROW_W = 5,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             we,
    input  logic [ROW_W-1:0] waddr,
    input  logic [LEN_W-1:0] wdata,
    input  logic             zero_we,
    input  logic [ROW_W-1:0] zero_addr,
    input  logic [ROW_W-1:0] raddr,
    output logic [LEN_W-1:0] rdata
);

    localparam int unsigned NROWS = 2 ** ROW_W;

    logic [LEN_W-1:0] len_q [NROWS];

    // Zero port is used for the row being opened, the data port for the row being closed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NROWS; i++) begin
            if (clear) begin
                len_q[i] <= '0;
            end else if (we && waddr == ROW_W'(i)) begin
                len_q[i] <= wdata;
            end else if (zero_we && zero_addr == ROW_W'(i)) begin
                len_q[i] <= '0;
            end
        end
    end

    assign rdata = len_q[raddr];

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal cursor tracker and character-buffer write controller with scroll,
// line clearing and control-code handling.
module text_console_ctrl
    import console_pkg::*;
#(
    parameter int unsigned COLS  = 70,
    parameter int unsigned ROWS  = 30,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned TAB_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   char_valid,
    input  logic [7:0]             char_data,
    output logic                   char_ready,
    output logic                   buf_we,
    output logic [COL_W+ROW_W-1:0] buf_addr,
    output logic [7:0]             buf_wdata,
    output logic [ROW_W-1:0]       line_offset,
    output logic [COL_W-1:0]       cur_col,
    output logic [ROW_W-1:0]       cur_row,
    output logic                   busy
);

    localparam int unsigned LEN_W = COL_W + 1;
    localparam logic [COL_W:0] COLS_L   = (COL_W+1)'(COLS);
    localparam logic [COL_W:0] LAST_CLR = (COL_W+1)'(COLS - 1);
    localparam logic [COL_W:0] TAB_STEP = (COL_W+1)'(TAB_W);
    localparam logic [COL_W:0] TAB_MASK = TAB_STEP - (COL_W+1)'(1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(COLS);

    state_e                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [ROW_W-1:0]       off_q, off_d;
    logic                   we_q, we_d;
    logic [COL_W+ROW_W-1:0] addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic [COL_W:0]         clr_col_q, clr_col_d;
    logic [ROW_W:0]         clr_row_q, clr_row_d;
    logic [ROW_W-1:0]       clr_tgt_q, clr_tgt_d;
    logic                   wrap_q, wrap_d;

    logic [ROW_W-1:0] phys_c, adv_row, adv_off, adv_phys, bs_row, bs_phys;
    logic [COL_W-1:0] bs_col;
    logic [COL_W:0]   tab_col;
    logic             tab_wrap, printable, go_line;
    logic             len_we, len_clear;
    logic [LEN_W-1:0] len_wdata, len_rdata;

    // Cursor arithmetic shared by all codes
    always_comb begin
        phys_c    = row_q + off_q;
        adv_row   = (row_q == ROW_W'(ROWS - 1)) ? row_q : row_q + ROW_W'(1);
        adv_off   = (row_q == ROW_W'(ROWS - 1)) ? off_q + ROW_W'(1) : off_q;
        adv_phys  = adv_row + adv_off;
        bs_row    = row_q - ROW_W'(1);
        bs_phys   = bs_row + off_q;
        bs_col    = (len_rdata == '0) ? '0 : COL_W'(len_rdata - LEN_W'(1));
        tab_col   = ({1'b0, col_q} & ~TAB_MASK) + TAB_STEP;
        tab_wrap  = (tab_col >= COLS_L);
        printable = (char_data >= ASC_PRINT_LO) && (char_data <= ASC_PRINT_HI);
    end

    line_len_table #(
        .ROW_W (ROW_W),
        .LEN_W (LEN_W)
    ) u_line_len (
        .clk       (clk),
        .clear     (len_clear),
        .we        (len_we),
        .waddr     (phys_c),
        .wdata     (len_wdata),
        .zero_we   (go_line || wrap_d),
        .zero_addr (adv_phys),
        .raddr     (bs_phys),
        .rdata     (len_rdata)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        off_d     = off_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        clr_tgt_d = clr_tgt_q;
        wrap_d    = 1'b0;
        go_line   = 1'b0;
        len_we    = 1'b0;
        len_wdata = '0;
        len_clear = 1'b0;

        case (state_q)
            CLR_ALL: begin
                len_clear = 1'b1;
                if (clr_row_q[ROW_W]) begin
                    state_d   = IDLE;
                    clr_row_d = '0;
                    clr_col_d = '0;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = {clr_col_q[COL_W-1:0], clr_row_q[ROW_W-1:0]};
                    wdata_d = 8'h00;
                    if (clr_col_q == LAST_CLR) begin
                        clr_col_d = '0;
                        clr_row_d = clr_row_q + (ROW_W+1)'(1);
                    end else begin
                        clr_col_d = clr_col_q + (COL_W+1)'(1);
                    end
                end
            end

            IDLE: begin
                if (char_valid && ready_q) begin
                    state_d = WRITE;
                    if (printable) begin
                        we_d    = 1'b1;
                        addr_d  = {col_q, phys_c};
                        wdata_d = char_data;
                        if (col_q == COL_W'(COLS - 1)) begin
                            len_we    = 1'b1;
                            len_wdata = LEN_FULL;
                            col_d     = '0;
                            row_d     = adv_row;
                            off_d     = adv_off;
                            wrap_d    = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else if (char_data == ASC_LF) begin
                        len_we    = 1'b1;
                        len_wdata = {1'b0, col_q};
                        go_line   = 1'b1;
                    end else if (char_data == ASC_CR) begin
                        col_d = '0;
                    end else if (char_data == ASC_HT) begin
                        if (tab_wrap) begin
                            len_we    = 1'b1;
                            len_wdata = LEN_FULL;
                            go_line   = 1'b1;
                        end else begin
                            col_d = tab_col[COL_W-1:0];
                        end
                    end else if (char_data == ASC_BS) begin
                        if (col_q != '0) begin
                            col_d   = col_q - COL_W'(1);
                            we_d    = 1'b1;
                            addr_d  = {col_q - COL_W'(1), phys_c};
                            wdata_d = 8'h00;
                        end else if (row_q != '0) begin
                            row_d   = bs_row;
                            col_d   = bs_col;
                            we_d    = 1'b1;
                            addr_d  = {bs_col, bs_phys};
                            wdata_d = 8'h00;
                        end
                    end else if (char_data == ASC_FF) begin
                        col_d     = '0;
                        row_d     = '0;
                        off_d     = '0;
                        clr_col_d = '0;
                        clr_row_d = '0;
                        state_d   = CLR_ALL;
                    end

                    // Line break: new line opens and its first clear write is issued now
                    if (go_line) begin
                        col_d     = '0;
                        row_d     = adv_row;
                        off_d     = adv_off;
                        we_d      = 1'b1;
                        addr_d    = {COL_W'(0), adv_phys};
                        wdata_d   = 8'h00;
                        clr_col_d = (COL_W+1)'(1);
                        clr_tgt_d = adv_phys;
                        state_d   = CLR_LINE;
                    end
                end
            end

            WRITE: begin
                if (wrap_q) begin
                    we_d      = 1'b1;
                    addr_d    = {COL_W'(0), phys_c};
                    wdata_d   = 8'h00;
                    clr_col_d = (COL_W+1)'(1);
                    clr_tgt_d = phys_c;
                    state_d   = CLR_LINE;
                end else begin
                    state_d = IDLE;
                end
            end

            CLR_LINE: begin
                if (clr_col_q == COLS_L) begin
                    state_d = IDLE;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = {clr_col_q[COL_W-1:0], clr_tgt_q};
                    wdata_d   = 8'h00;
                    clr_col_d = clr_col_q + (COL_W+1)'(1);
                end
            end

            default: state_d = CLR_ALL;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CLR_ALL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLR_ALL;
            col_q     <= '0;
            row_q     <= '0;
            off_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            clr_col_q <= '0;
            clr_row_q <= '0;
            clr_tgt_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            off_q     <= off_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
            clr_tgt_q <= clr_tgt_d;
            wrap_q    <= wrap_d;
        end
    end

    assign char_ready  = ready_q;
    assign buf_we      = we_q;
    assign buf_addr    = addr_q;
    assign buf_wdata   = wdata_q;
    assign line_offset = off_q;
    assign cur_col     = col_q;
    assign cur_row     = row_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: vector table, hand-written corner
// sequences and random codes against a screen-level reference model.
module tb_text_console_ctrl;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int COL_W = 7;
    localparam int ROW_W = 5;
    localparam int TAB_W = 8;
    localparam int NP    = 32;
    localparam int BOUND = 3000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   char_valid;
    logic [7:0]             char_data;
    logic                   char_ready;
    logic                   buf_we;
    logic [COL_W+ROW_W-1:0] buf_addr;
    logic [7:0]             buf_wdata;
    logic [ROW_W-1:0]       line_offset;
    logic [COL_W-1:0]       cur_col;
    logic [ROW_W-1:0]       cur_row;
    logic                   busy;

    text_console_ctrl #(
        .COLS (COLS), .ROWS (ROWS), .COL_W (COL_W), .ROW_W (ROW_W), .TAB_W (TAB_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_wdata   (buf_wdata),
        .line_offset (line_offset),
        .cur_col     (cur_col),
        .cur_row     (cur_row),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int got_q[$];
    int exp_q[$];

    // Reference model state: cursor, scroll and per-physical-row lengths
    int m_col, m_row, m_off;
    int m_len[NP];

    always @(negedge clk) begin
        if (buf_we === 1'b1) got_q.push_back(int'({buf_addr, buf_wdata}));
    end

    typedef struct {
        logic [7:0] code;
        int col;
        int row;
        int off;
        int lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wr(input int col, input int phys, input int data);
        return (((col << ROW_W) | phys) << 8) | data;
    endfunction

    function automatic int m_phys();
        return (m_row + m_off) % NP;
    endfunction

    task automatic model_clear_line(input int p);
        m_len[p] = 0;
        for (int c = 0; c < COLS; c++) exp_q.push_back(wr(c, p, 0));
    endtask

    task automatic model_break(input int len);
        m_len[m_phys()] = len;
        m_col = 0;
        if (m_row == ROWS - 1) m_off = (m_off + 1) % NP;
        else m_row = m_row + 1;
        model_clear_line(m_phys());
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_off = 0;
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            m_len[p] = 0;
            for (int c = 0; c < COLS; c++) exp_q.push_back(wr(c, p, 0));
        end
    endtask

    task automatic model_step(input logic [7:0] c, output int lat);
        int t, p;
        exp_q.delete();
        lat = 2;
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back(wr(m_col, m_phys(), int'(c)));
            if (m_col == COLS - 1) begin
                model_break(COLS);
                lat = 0;
            end else begin
                m_col++;
            end
        end else if (c == 8'h0A) begin
            model_break(m_col);
            lat = COLS + 1;
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h09) begin
            t = (m_col / TAB_W) * TAB_W + TAB_W;
            if (t >= COLS) begin
                model_break(COLS);
                lat = COLS + 1;
            end else begin
                m_col = t;
            end
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back(wr(m_col, m_phys(), 0));
            end else if (m_row > 0) begin
                m_row--;
                p = m_phys();
                m_col = (m_len[p] > 0) ? m_len[p] - 1 : 0;
                exp_q.push_back(wr(m_col, p, 0));
            end
        end else if (c == 8'h0C) begin
            model_reset();
            lat = 0;
        end
    endtask

    task automatic cmp_writes(input string name);
        int bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
        end
        n_chk++;
        if (bad >= 0 || got_q.size() != exp_q.size()) begin
            n_fail++;
            if (bad >= 0)
                $display("FAIL %s writes: entry %0d got %05h expected %05h ({col,row,data})",
                         name, bad, got_q[bad], exp_q[bad]);
            else
                $display("FAIL %s writes: got %0d writes expected %0d", name, got_q.size(), exp_q.size());
        end
    endtask

    task automatic chk_cursor(input string name);
        chk({name, " cur_col"}, 32'(cur_col), 32'(m_col));
        chk({name, " cur_row"}, 32'(cur_row), 32'(m_row));
        chk({name, " line_offset"}, 32'(line_offset), 32'(m_off));
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, " char_ready"}, 32'(char_ready), 0);
        chk({name, " buf_we"}, 32'(buf_we), 0);
        chk({name, " buf_addr"}, 32'(buf_addr), 0);
        chk({name, " buf_wdata"}, 32'(buf_wdata), 0);
        chk({name, " line_offset"}, 32'(line_offset), 0);
        chk({name, " cur_col"}, 32'(cur_col), 0);
        chk({name, " cur_row"}, 32'(cur_row), 0);
        chk({name, " busy"}, 32'(busy), 1);
    endtask

    // Leaves the bench at a falling edge with char_ready high
    task automatic release_and_check(input string name);
        int lat;
        got_q.delete();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk({name, " busy early"}, 32'(busy), 1);
        lat = 1;
        while (char_ready !== 1'b1 && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " ready reached"}, 32'(char_ready), 1);
        cmp_writes(name);
        chk({name, " busy done"}, 32'(busy), 0);
        chk_cursor(name);
    endtask

    // Transfer one code, wait for ready (wiggling valid meanwhile), check against model
    task automatic send(input logic [7:0] c, output int lat);
        int exp_lat;
        string name;
        name = $sformatf("code %02h", c);
        got_q.delete();
        char_valid = 1'b1;
        char_data  = c;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        lat = 1;
        while (char_ready !== 1'b1 && lat < BOUND) begin
            char_valid = 1'($urandom_range(0, 1));
            char_data  = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        char_valid = 1'b0;
        model_step(c, exp_lat);
        chk({name, " ready reached"}, 32'(char_ready), 1);
        if (exp_lat != 0) chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        cmp_writes(name);
        chk_cursor(name);
    endtask

    initial begin
        int lat, k, r;
        logic [7:0] c;

        vecs[0]  = '{8'h41, 1, 0, 0, 2};
        vecs[1]  = '{8'h42, 2, 0, 0, 2};
        vecs[2]  = '{8'h0D, 0, 0, 0, 2};
        vecs[3]  = '{8'h09, 8, 0, 0, 2};
        vecs[4]  = '{8'h09, 16, 0, 0, 2};
        vecs[5]  = '{8'h08, 15, 0, 0, 2};
        vecs[6]  = '{8'h7A, 16, 0, 0, 2};
        vecs[7]  = '{8'h0A, 0, 1, 0, 71};
        vecs[8]  = '{8'h08, 15, 0, 0, 2};
        vecs[9]  = '{8'h01, 15, 0, 0, 2};
        vecs[10] = '{8'h7F, 15, 0, 0, 2};
        vecs[11] = '{8'h08, 14, 0, 0, 2};
        vecs[12] = '{8'h20, 15, 0, 0, 2};
        vecs[13] = '{8'h7E, 16, 0, 0, 2};
        vecs[14] = '{8'h1F, 16, 0, 0, 2};
        vecs[15] = '{8'h0D, 0, 0, 0, 2};
        vecs[16] = '{8'h08, 0, 0, 0, 2};

        reset = 1'b1;
        char_valid = 1'b0;
        char_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        release_and_check("reset release");

        for (int i = 0; i < 17; i++) begin
            send(vecs[i].code, lat);
            chk($sformatf("vec %0d col", i), 32'(cur_col), 32'(vecs[i].col));
            chk($sformatf("vec %0d row", i), 32'(cur_row), 32'(vecs[i].row));
            chk($sformatf("vec %0d off", i), 32'(line_offset), 32'(vecs[i].off));
            chk($sformatf("vec %0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Full-line wrap then backspace across the wrap
        send(8'h0C, lat);
        for (int i = 0; i < COLS; i++) send(8'h78, lat);
        chk("wrap col", 32'(cur_col), 0);
        chk("wrap row", 32'(cur_row), 1);
        chk("wrap write count", 32'(got_q.size()), 71);
        send(8'h08, lat);
        chk("bs-wrap col", 32'(cur_col), 69);
        chk("bs-wrap row", 32'(cur_row), 0);
        chk("bs-wrap write count", 32'(got_q.size()), 1);
        if (got_q.size() > 0) chk("bs-wrap write", 32'(got_q[0]), 32'(wr(69, 0, 0)));

        // Tab stops and tab-induced wrap
        send(8'h0A, lat);
        for (int i = 0; i < 5; i++) send(8'h61, lat);
        send(8'h09, lat);
        chk("tab col", 32'(cur_col), 8);
        chk("tab no write", 32'(got_q.size()), 0);
        for (int i = 0; i < 59; i++) send(8'h62, lat);
        chk("pre-tab col", 32'(cur_col), 67);
        send(8'h09, lat);
        chk("tab wrap col", 32'(cur_col), 0);
        chk("tab wrap row", 32'(cur_row), 2);
        chk("tab wrap latency", 32'(lat), 71);

        // Scroll from the bottom visible row
        send(8'h0C, lat);
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A, lat);
        chk("bottom row", 32'(cur_row), 29);
        send(8'h0A, lat);
        chk("scroll offset", 32'(line_offset), 1);
        chk("scroll row", 32'(cur_row), 29);
        chk("scroll clear count", 32'(got_q.size()), 70);
        if (got_q.size() == 70) begin
            chk("scroll clear first", 32'(got_q[0]), 32'(wr(0, 30, 0)));
            chk("scroll clear last", 32'(got_q[69]), 32'(wr(69, 30, 0)));
        end

        // Form feed aborted by reset partway through the clear
        send(8'h41, lat);
        got_q.delete();
        char_valid = 1'b1;
        char_data  = 8'h0C;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        k = 0;
        while (got_q.size() < 100 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("ff clear progress", 32'(got_q.size() >= 100), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_values("abort reset");
        release_and_check("clear restart");

        // Random codes with idle gaps
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 68)      c = 8'($urandom_range(32, 126));
            else if (r < 73) c = 8'h0A;
            else if (r < 78) c = 8'h0D;
            else if (r < 88) c = 8'h09;
            else if (r < 97) c = 8'h08;
            else             c = 8'h80 | 8'($urandom_range(0, 127));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(c, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
